// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU for the execute stage of the MIPS datapath.
//
// Single-cycle ops (add, sub, slt, or, and, shl, srl, xor) produce their
// result one edge after accept. MUL (shift-add) and DIVU/REMU (restoring
// division) iterate one bit per cycle for WIDTH cycles. The result and its
// flags are held until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/opcode presented
//   in_ready   idle and accepting (state decode)
//   inpA/inpB  operands; inpB[SHW-1:0] is the shift amount
//   opc        4-bit operation code (11..15 illegal)
//   out_valid  result held valid
//   out_ready  consumer takes result
//   res        result
//   zero       res == 0
//   carry      ADD carry-out / SUB borrow / MUL high half non-zero
//   ovf        signed overflow for ADD/SUB
//   err        divide by zero or illegal opcode
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inpA,
  input  logic [WIDTH-1:0] inpB,
  input  logic [3:0]       opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIVU = 4'd7;
  localparam logic [3:0] OP_REMU = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state_reg, state_next;

  logic             accept;
  logic             is_iter;

  // captured operands and iteration state
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [3:0]         op_reg;
  logic [SHW-1:0]     count_reg;
  logic [2*WIDTH-2:0] acc_reg;   // partial product never exceeds 2W-1 bits before the last step
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;

  // registered result and flags
  logic [WIDTH-1:0] res_reg;
  logic             zero_reg, carry_reg, ovf_reg, err_reg;

  assign accept  = in_valid && in_ready;
  assign is_iter = (opc == OP_MUL) || (opc == OP_DIVU) || (opc == OP_REMU);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = is_iter ? BUSY : DONE;
      BUSY: if (count_reg == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready is masked by rst so nothing is offered while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_full, sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] simple_res;
  logic             simple_carry, simple_ovf, simple_err;

  assign add_full = {1'b0, inpA} + {1'b0, inpB};
  assign sub_full = {1'b0, inpA} - {1'b0, inpB};
  assign shamt    = inpB[SHW-1:0];

  always_comb begin
    simple_res   = '0;
    simple_carry = 1'b0;
    simple_ovf   = 1'b0;
    simple_err   = 1'b0;
    case (opc)
      OP_ADD: begin
        simple_res   = add_full[WIDTH-1:0];
        simple_carry = add_full[WIDTH];
        // same-sign operands producing a different-sign sum
        simple_ovf   = (inpA[WIDTH-1] == inpB[WIDTH-1]) && (add_full[WIDTH-1] != inpA[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res   = sub_full[WIDTH-1:0];
        simple_carry = sub_full[WIDTH];   // borrow: unsigned A < B
        simple_ovf   = (inpA[WIDTH-1] != inpB[WIDTH-1]) && (sub_full[WIDTH-1] != inpA[WIDTH-1]);
      end
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(inpA) < $signed(inpB))};
      OP_OR:   simple_res = inpA | inpB;
      OP_AND:  simple_res = inpA & inpB;
      OP_SHL:  simple_res = inpA << shamt;
      OP_SRL:  simple_res = inpA >> shamt;
      OP_XOR:  simple_res = inpA ^ inpB;
      OP_MUL, OP_DIVU, OP_REMU: ;        // handled by the iterative path
      default: simple_err = 1'b1;        // illegal opcode: res stays 0
    endcase
  end

  // ---------------- iterative datapath (one bit per BUSY cycle) ----------------
  // Both MUL and DIV walk the operand bits MSB first, indexed by count_reg.
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   iter_res;
  logic               iter_carry, iter_err;

  assign acc_step = {acc_reg, 1'b0} + {{WIDTH{1'b0}}, (b_reg[count_reg] ? a_reg : {WIDTH{1'b0}})};
  assign rem_sh   = {rem_reg, a_reg[count_reg]};
  assign rem_ge   = rem_sh >= {1'b0, b_reg};
  // After a successful subtract the remainder is below B, so W bits suffice.
  // With B == 0 every step "subtracts" zero: quotient all ones, remainder A.
  assign rem_step = rem_ge ? (rem_sh[WIDTH-1:0] - b_reg) : rem_sh[WIDTH-1:0];

  always_comb begin
    quo_step            = quo_reg;
    quo_step[count_reg] = rem_ge;
  end

  always_comb begin
    iter_res   = '0;
    iter_carry = 1'b0;
    iter_err   = 1'b0;
    case (op_reg)
      OP_MUL: begin
        iter_res   = acc_step[WIDTH-1:0];
        iter_carry = |acc_step[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        iter_res = quo_step;
        iter_err = (b_reg == '0);
      end
      OP_REMU: begin
        iter_res = rem_step;
        iter_err = (b_reg == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      res_reg   <= '0;
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= inpA;
            b_reg     <= inpB;
            op_reg    <= opc;
            count_reg <= SHW'(WIDTH - 1);
            acc_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            if (!is_iter) begin
              res_reg   <= simple_res;
              zero_reg  <= (simple_res == '0);
              carry_reg <= simple_carry;
              ovf_reg   <= simple_ovf;
              err_reg   <= simple_err;
            end
          end
        end
        BUSY: begin
          acc_reg   <= acc_step[2*WIDTH-2:0];
          rem_reg   <= rem_step;
          quo_reg   <= quo_step;
          count_reg <= count_reg - SHW'(1);
          // final bit: load the result straight from this cycle's step
          if (count_reg == '0) begin
            res_reg   <= iter_res;
            zero_reg  <= (iter_res == '0);
            carry_reg <= iter_carry;
            ovf_reg   <= 1'b0;
            err_reg   <= iter_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign res   = res_reg;
  assign zero  = zero_reg;
  assign carry = carry_reg;
  assign ovf   = ovf_reg;
  assign err   = err_reg;

endmodule
